ws2812_pixel_driver: RTL
========================

# ws2812_pixel_driver

- Serial-line output stage of the WS2812 LED chain, downstream of the configuration controller.
- On each `write` strobe it latches the frame configuration: LED count, inter-frame delay and frame count.
- It pulls 24-bit GRB pixels from the pixel FIFO and serialises them MSB-first onto the single-wire `dout` with WS2812 bit timing.
- It inserts a latch/reset gap after every frame and repeats frames as configured.

## Interface
- `T0H`, 20: clocks `dout` is high for a 0 bit.
- `T1H`, 40: clocks `dout` is high for a 1 bit.
- `TBIT`, 63: total clocks per bit. Constraint: T0H < T1H < TBIT.
- `RESET_CYCLES`, 2500: minimum low gap after a frame, in clocks.
- `CLK_PER_US`, 50: clocks per microsecond; scales `data_delay`.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `write`  in  1  one-cycle strobe: latch `num_leds`, `data_delay`, `data_length`.
- `num_leds`  in  16  pixels per frame; 0 = no output.
- `data_delay`  in  16  extra inter-frame gap in µs.
- `data_length`  in  16  frames to send; 0 = repeat until next `write`.
- `px_empty`  in  1  pixel FIFO empty.
- `px_read_data`  in  24  pixel word {G,R,B}; valid the cycle after `px_read_en`.
- `px_read_en`  out  1  single-cycle pixel FIFO pop.
- `dout`  out  1  WS2812 serial data line.
- `busy`  out  1  high from frame start until the last latch gap ends.
- `frame_done`  out  1  one-cycle pulse at the end of each latch gap.
- `underflow`  out  1  sticky: a pixel was needed mid-frame and the FIFO was empty.

## Operation
- Reset: all outputs 0. State IDLE. Shadow config = 0. Counters cleared. Asserting reset mid-bit forces `dout` low immediately.
- `write` in any state:
  - copies the inputs into the pending config and clears `underflow`.
  - Pending config becomes active only at a frame boundary: IDLE, or at the end of LATCH. A frame in progress is never altered.
  - The frame counter restarts when new config is applied.
- States:
  - IDLE: `dout` = 0. If pending config is valid and its `num_leds` ≠ 0: apply it and go to PRIME.
  - PRIME: pops the first pixel. While `px_empty`, waits with `dout` low (harmless, because the line is idle). On pop, goes to LOAD.
  - LOAD: captures `px_read_data` into the 24-bit shift register and sets bit_cnt = 23. Goes to SEND.
  - SEND: phase counter runs 0..TBIT-1. `dout` = 1 while phase < (bit ? T1H : T0H), else 0. Shifts left at phase TBIT-1.
    - After bit 0 of the last pixel (pixel_cnt = num_leds-1), go to LATCH.
  - LATCH: `dout` = 0 for gap = max(RESET_CYCLES, data_delay·CLK_PER_US) clocks. Compute with 32-bit arithmetic; no truncation.
    - At the end of the gap: pulse `frame_done` and increment frame_cnt.
    - If data_length ≠ 0 and frame_cnt = data_length, go to IDLE. Otherwise go to PRIME.
- Prefetch:
  - In the cycle after LOAD, if more pixels remain, the driver pops the next pixel into a holding register. It retries every cycle while `px_empty`.
  - At the end of bit 0, the shift register reloads from the holding register, so there is no inter-pixel gap.
  - If no pixel has arrived by the end of bit 0, the driver loads 0x000000 and sets `underflow`.
  - The FIFO is never popped for a pixel beyond `num_leds`.
- `busy` = 1 in PRIME, LOAD, SEND and LATCH.

## Timing
- IDLE with `px_empty` = 0, `write` sampled at edge 0:
  - `px_read_en` is high in cycle 1.
  - Data is captured at the end of cycle 2.
  - The first `dout` rise is in cycle 3.
- Every bit is exactly TBIT clocks. A frame occupies exactly 24·num_leds·TBIT clocks of SEND, then gap clocks of LATCH.
- `frame_done` is asserted in the last LATCH cycle. `busy` falls the cycle after the final `frame_done`.
- At most one `px_read_en` per pixel. `px_read_en` is never high in two consecutive cycles.
- `write` in the same cycle as the LATCH end: the new config applies to the next frame.

## Test plan
- Default parameters. Load one pixel 0xFF0000; `num_leds`=1, `data_length`=1, `data_delay`=0. Expected:
  - `dout` shows 8 highs of 40 clocks, then 16 highs of 20 clocks, each bit 63 clocks.
  - `dout` then stays low for 2500 clocks.
  - One `frame_done` pulse, then `busy` = 0.
- Three pixels preloaded (0x000001, 0x800000, 0x00FF00), `num_leds`=3. Expected:
  - 72 contiguous bits with no gap.
  - Exactly 3 `px_read_en` pulses.
  - Bit values match the pixels MSB-first.
- `num_leds`=2 with only 0xFFFFFF in the FIFO. Expected:
  - The second pixel is 24 bits of 20-clock highs.
  - `underflow` = 1 and stays 1 until the next `write`.
- `data_delay`=100, `data_length`=2, 1 LED. Expected:
  - Two frames, each followed by a 5000-clock low gap.
  - Two `frame_done` pulses, then IDLE.
- Mid-frame `write` changing `num_leds` 4→1. Expected: the current frame sends all 4 pixels; the next frame sends 1.
- Assert `reset` during a high phase. Expected:
  - `dout`, `busy` and `px_read_en` go low without a clock edge.
  - After release, the block stays IDLE until `write`.

Source files
------------

// File: rtl/ws2812_pixel_driver_if.sv
// Bus between the WS2812 serial driver and its environment: frame configuration
// strobe, pixel FIFO read port and the serial line plus status outputs.
interface ws2812_pixel_driver_if;
  logic        write;
  logic [15:0] num_leds;
  logic [15:0] data_delay;
  logic [15:0] data_length;
  logic        px_empty;
  logic [23:0] px_read_data;
  logic        px_read_en;
  logic        dout;
  logic        busy;
  logic        frame_done;
  logic        underflow;

  modport master (
    output write, num_leds, data_delay, data_length, px_empty, px_read_data,
    input  px_read_en, dout, busy, frame_done, underflow
  );

  modport slave (
    input  write, num_leds, data_delay, data_length, px_empty, px_read_data,
    output px_read_en, dout, busy, frame_done, underflow
  );
endinterface

// File: rtl/ws2812_pixel_driver.sv
// WS2812 serial output stage: pulls GRB pixels from a FIFO and serialises them
// MSB-first with WS2812 bit timing, inserting a latch gap after every frame.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | line low, waiting for a valid config with num_leds != 0
// PRIME | popping the first pixel of a frame (waits while FIFO empty)
// LOAD  | first pixel on px_read_data, captured into the shift register
// SEND  | shifting bits out, one bit per TBIT clocks, next pixel prefetched
// LATCH | line low for the latch gap, then next frame or back to IDLE
module ws2812_pixel_driver #(
  parameter int T0H          = 20,
  parameter int T1H          = 40,
  parameter int TBIT         = 63,
  parameter int RESET_CYCLES = 2500,
  parameter int CLK_PER_US   = 50
) (
  input  logic                  clk,
  input  logic                  reset,
  ws2812_pixel_driver_if.slave  bus
);

  localparam int PW = $clog2(TBIT);
  localparam logic [PW-1:0] PH_LAST  = PW'(TBIT - 1);
  localparam logic [PW-1:0] PH_T0H   = PW'(T0H);
  localparam logic [PW-1:0] PH_T1H   = PW'(T1H);
  localparam logic [PW-1:0] PH_ONE   = PW'(1);
  localparam logic [31:0]   GAP_MIN  = 32'(RESET_CYCLES);
  localparam logic [15:0]   US_SCALE = 16'(CLK_PER_US);

  typedef enum logic [2:0] {IDLE, PRIME, LOAD, SEND, LATCH} state_t;
  state_t state;

  logic        pend_valid;
  logic [15:0] pend_leds, pend_delay, pend_length;
  logic [15:0] act_leds, act_delay, act_length;
  logic [15:0] frame_cnt, pixel_cnt;
  logic [23:0] shift_q, hold_q;
  logic        hold_valid, hold_wait;
  logic [PW-1:0] phase;
  logic [4:0]  bit_cnt;
  logic [31:0] gap_cnt;

  logic        new_valid;
  logic [15:0] new_leds, new_delay, new_length;
  logic [31:0] delay_clks, gap_len;
  logic [PW-1:0] phase_nx, thr;
  logic        bit_end, last_px, more_px, fetch_ok;
  logic [15:0] frame_nx;

  // Config selection (a write in the same cycle wins), gap length and bit-timing helpers.
  always_comb begin
    new_valid  = bus.write | pend_valid;
    new_leds   = bus.write ? bus.num_leds    : pend_leds;
    new_delay  = bus.write ? bus.data_delay  : pend_delay;
    new_length = bus.write ? bus.data_length : pend_length;
    delay_clks = 32'(act_delay) * 32'(US_SCALE);
    gap_len    = (delay_clks > GAP_MIN) ? delay_clks : GAP_MIN;
    phase_nx   = phase + PH_ONE;
    thr        = shift_q[23] ? PH_T1H : PH_T0H;
    bit_end    = (phase == PH_LAST) && (bit_cnt == 5'd0);
    last_px    = ({1'b0, pixel_cnt} + 17'd1) == {1'b0, act_leds};
    more_px    = ({1'b0, pixel_cnt} + 17'd1) <  {1'b0, act_leds};
    // Never pop on a reload edge: pixel_cnt is about to move and the slot may already be spent.
    fetch_ok   = ((state == LOAD) || ((state == SEND) && !bit_end)) && more_px &&
                 !hold_valid && !hold_wait && !bus.px_read_en && !bus.px_empty;
    frame_nx   = frame_cnt + 16'd1;
  end

  // Frame sequencer, serialiser and prefetch with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      pend_valid     <= 1'b0;
      pend_leds      <= '0;
      pend_delay     <= '0;
      pend_length    <= '0;
      act_leds       <= '0;
      act_delay      <= '0;
      act_length     <= '0;
      frame_cnt      <= '0;
      pixel_cnt      <= '0;
      shift_q        <= '0;
      hold_q         <= '0;
      hold_valid     <= 1'b0;
      hold_wait      <= 1'b0;
      phase          <= '0;
      bit_cnt        <= '0;
      gap_cnt        <= '0;
      bus.px_read_en <= 1'b0;
      bus.dout       <= 1'b0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
      bus.underflow  <= 1'b0;
    end else begin
      bus.frame_done <= 1'b0;
      bus.px_read_en <= 1'b0;

      if (bus.write) begin
        pend_valid  <= 1'b1;
        pend_leds   <= bus.num_leds;
        pend_delay  <= bus.data_delay;
        pend_length <= bus.data_length;
      end

      // Prefetch pops land in the holding register one cycle after px_read_en.
      hold_wait <= bus.px_read_en && (state != PRIME);
      if (hold_wait) begin
        hold_q     <= bus.px_read_data;
        hold_valid <= 1'b1;
      end
      if (fetch_ok) bus.px_read_en <= 1'b1;

      case (state)
        IDLE: begin
          bus.dout <= 1'b0;
          bus.busy <= 1'b0;
          if (new_valid) begin
            act_leds   <= new_leds;
            act_delay  <= new_delay;
            act_length <= new_length;
            pend_valid <= 1'b0;
            frame_cnt  <= '0;
            pixel_cnt  <= '0;
            if (new_leds != 16'd0) begin
              state    <= PRIME;
              bus.busy <= 1'b1;
              if (!bus.px_empty) bus.px_read_en <= 1'b1;
            end
          end
        end

        PRIME: begin
          hold_valid <= 1'b0;
          pixel_cnt  <= '0;
          if (bus.px_read_en) state <= LOAD;
          else if (!bus.px_empty) bus.px_read_en <= 1'b1;
        end

        LOAD: begin
          shift_q  <= bus.px_read_data;
          bit_cnt  <= 5'd23;
          phase    <= '0;
          bus.dout <= 1'b1;
          state    <= SEND;
        end

        SEND: begin
          if (phase == PH_LAST) begin
            phase <= '0;
            if (bit_cnt != 5'd0) begin
              shift_q  <= {shift_q[22:0], 1'b0};
              bit_cnt  <= bit_cnt - 5'd1;
              bus.dout <= 1'b1;
            end else if (last_px) begin
              state          <= LATCH;
              bus.dout       <= 1'b0;
              gap_cnt        <= gap_len - 32'd1;
              bus.frame_done <= (gap_len == 32'd1);
            end else begin
              pixel_cnt <= pixel_cnt + 16'd1;
              bit_cnt   <= 5'd23;
              bus.dout  <= 1'b1;
              if (hold_valid) begin
                shift_q    <= hold_q;
                hold_valid <= 1'b0;
              end else begin
                shift_q       <= '0;
                bus.underflow <= 1'b1;
              end
            end
          end else begin
            phase    <= phase_nx;
            bus.dout <= (phase_nx < thr);
          end
        end

        LATCH: begin
          bus.dout <= 1'b0;
          if (gap_cnt == 32'd1) bus.frame_done <= 1'b1;
          if (gap_cnt == 32'd0) begin
            if (new_valid) begin
              act_leds   <= new_leds;
              act_delay  <= new_delay;
              act_length <= new_length;
              pend_valid <= 1'b0;
              frame_cnt  <= '0;
              if (new_leds != 16'd0) begin
                state <= PRIME;
                if (!bus.px_empty) bus.px_read_en <= 1'b1;
              end else begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end
            end else begin
              frame_cnt <= frame_nx;
              if ((act_length != 16'd0) && (frame_nx == act_length)) begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end else begin
                state <= PRIME;
                if (!bus.px_empty) bus.px_read_en <= 1'b1;
              end
            end
          end else begin
            gap_cnt <= gap_cnt - 32'd1;
          end
        end

        default: state <= IDLE;
      endcase

      if (bus.write) bus.underflow <= 1'b0;
    end
  end

endmodule
